// File: rtl/alu_sequencer.sv
// Issue controller in front of the shared ALU/ALU-control pair.
// MUL is run as WIDTH shift-and-add passes through the ALU's ADD.
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_op,
  output logic [3:0]       alu_func,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] PASS   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE, EXEC, MULT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    alu_op   = '0;
    alu_func = '0;
    alu_a    = '0;
    alu_b    = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (op == OP_MUL) ? MULT : EXEC;
        end
      end
      EXEC: begin
        alu_op   = PASS;
        alu_func = op_q;
        alu_a    = a_q;
        alu_b    = b_q;
        res_d    = alu_y;
        state_d  = DONE;
      end
      MULT: begin
        // one partial product per pass, always WIDTH passes
        alu_op   = PASS;
        alu_func = OP_ADD;
        alu_a    = acc_q;
        alu_b    = b_q[0] ? a_q : '0;
        acc_d    = alu_y;
        a_d      = a_q << 1;
        b_d      = b_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = alu_y;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue controller between the instruction decode stage and the shared ALU/ALU-control pair. Accepts one operation at a time, drives ALU-control in pass-through mode (ALUop = 4'b1111, FuncCode = operation code), and returns a registered result with a done pulse. Single-cycle operations take one ALU pass. MUL, which the ALU lacks, is sequenced as WIDTH shift-and-add passes through the ALU's ADD function.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits (≥2).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  request; sampled only in IDLE.
- op  in  4  operation code: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110, SLT 4'b0111, MUL 4'b1100; any other code goes to the ALU unchanged as a single pass.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  registered result; held until the next accepted start.
- alu_op  out  4  to ALU-control ALUop.
- alu_func  out  4  to ALU-control FuncCode.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_y  in  WIDTH  ALU result, combinational from alu_a/alu_b/ALUCtrl.

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE → EXEC when start=1 and op≠MUL. IDLE → MUL when start=1 and op=MUL. On acceptance, capture op, a and b into op_r, a_r and b_r. Clear the accumulator acc and the iteration counter cnt to 0.
- EXEC: alu_op=4'b1111, alu_func=op_r, alu_a=a_r, alu_b=b_r. Latch result<=alu_y, then go to DONE.
- MUL: alu_op=4'b1111, alu_func=4'b0010 (ADD), alu_a=acc, alu_b = b_r[0] ? a_r : 0. Each cycle:
  - acc<=alu_y
  - a_r<=a_r<<1
  - b_r<=b_r>>1
  - cnt<=cnt+1
- MUL always runs exactly WIDTH iterations; there is no early exit when b_r reaches 0. On the iteration with cnt=WIDTH-1, latch result<=alu_y and go to DONE.
- Product is the low WIDTH bits of unsigned a×b. Overflow bits are discarded. Signed operands give the correct low WIDTH bits (two's complement).
- cnt width is clog2(WIDTH)+1.
- DONE: done=1 for this cycle only. Return to IDLE unconditionally.
- start while busy, including in DONE, is ignored and not queued. A request is lost unless re-asserted in IDLE.
- Idle ALU drive: alu_op=4'b0000, alu_func=4'b0000, alu_a=0, alu_b=0. This keeps ALU-control out of pass-through mode.
- reset at any time, including mid-MUL:
  - next state is IDLE
  - busy=0, done=0, result=0
  - acc=0, cnt=0, and ALU drive at idle values
  - no done pulse for the aborted operation.

## Timing
- Reset values: busy=0, done=0, result=0, alu_op=0, alu_func=0, alu_a=0, alu_b=0.
- Single-pass op, start sampled at edge 0: EXEC in cycle 1 (busy=1); DONE in cycle 2 (done=1, result valid). Latency is 2 cycles from the start edge to done.
- MUL, start at edge 0: MUL in cycles 1..WIDTH; DONE in cycle WIDTH+1. For WIDTH=16, done is in cycle 17.
- Outputs alu_* are combinational from state and registers; no combinational path from start/op/a/b.
- Back-to-back: earliest next accept is the cycle after DONE (IDLE). Minimum issue interval is 3 cycles for single-pass ops and WIDTH+2 for MUL.
- result changes only on the edge that enters DONE, or on reset.

## Test plan
- Reset, then ADD a=16'h0005, b=16'h0003 → done in cycle 2, result=16'h0008; alu_op=4'b1111 and alu_func=4'b0010 during EXEC.
- SUB a=16'h0003, b=16'h0005 → result=16'hFFFE. SLT with the same operands → result=16'h0001 (via the ALU model).
- MUL a=16'h0007, b=16'h0009 → busy for 17 cycles, done in cycle 17, result=16'h003F. MUL a=16'hFFFF, b=16'hFFFF → result=16'h0001.
- start held high through a MUL with a second op=ADD → the ADD is ignored, exactly one done pulse. Re-asserting start in IDLE is accepted.
- reset asserted in cycle 8 of a MUL → cycle 9 is IDLE with result=0, no done pulse. A following ADD 2+2 returns 4.
- op=4'b1010 (unknown), a=16'h1234 → alu_func=4'b1010 during EXEC, result equals the model ALU output, done in cycle 2.
